sprite_animator: RTL and testbench
==================================

// Module: sprite_animator
// PURPOSE
//   Parametrised successor to the single moving-pixel demo. Animates N_SPRITES
//   one-pixel sprites on the 8x8 DM163 colour shield. Sprite i lives on row i.
//   Each sprite moves horizontally by one column every (step_div+1) shield frames.
//   Edge handling is runtime-selectable between wrap and bounce. The block erases
//   old positions itself, so several sprites can be shown at once.
//   Sits between app logic and colorshield; drives its write_en/pixel_addr/pixel_value.
// PARAMETERS
//   N_SPRITES  4                 number of sprites, 1..8 (sprite i on row i)
//   DIV_W      8                 width of frame prescaler / step_div
//   PALETTE    {8{24'hff0000}}   192b packed; sprite i colour = PALETTE[24*i +: 24]
// PORTS
//   clk          in   1      system clock
//   rst_n        in   1      reset; asynchronous assert, active-low
//   run          in   1      1 = sprites advance; 0 = frozen (still redrawn)
//   bounce       in   1      0 = wrap mode, 1 = bounce mode; sampled at step time
//   step_div     in   DIV_W  frames per step minus 1; sampled at prescaler reload
//   ready        in   1      colorshield ready (high = INPUT phase, writes accepted)
//   write_en     out  1      one-cycle pixel write strobe to colorshield
//   pixel_addr   out  6      {row[2:0], col[2:0]} of current write
//   pixel_value  out  24     RGB of current write (24'h000000 for erase)
//   busy         out  1      high while a write sequence is pending or active
// BEHAVIOUR
// - Reset state:
//   - Outputs: write_en=0, pixel_addr=0, pixel_value=0, busy=0.
//   - Sprite start: even i at col 0, dir +1; odd i at col 7, dir -1.
//   - Prescaler=0; first_frame=1; pending=0; FSM=IDLE.
//   - Reset mid-sequence aborts it; no further writes until the next ready edge.
// - Frame tick:
//   - ready_q is ready registered; tick = ready & ~ready_q.
// - On tick:
//   - Prescaler: if 0, reload with step_div and step=run; else decrement, step=0.
//   - If step:
//     - Copy each sprite's col to old_col.
//     - Update col: wrap mode col=(col+dir) mod 8.
//     - Bounce mode at an outward edge (col 7, dir +1 / col 0, dir -1): negate dir;
//       col moves one inward (7->6, 0->1). Otherwise col+=dir.
//   - Sequence type: do_erase = step & ~first_frame; then clear first_frame.
// - FSM:
//   - IDLE -> ERASE (if do_erase) or DRAW, in the cycle after tick.
//   - ERASE idx 0..N-1 -> DRAW idx 0..N-1 -> IDLE.
//   - ERASE write: addr {i,old_col[i]}, value 0.
//   - DRAW write: addr {i,col[i]}, value PALETTE[i].
// - Write timing:
//   - One write per cycle; write_en high exactly one cycle per write.
//   - Addr/value valid in the same cycle as write_en.
//   - First write_en occurs 1 cycle after the tick cycle.
//   - Full sequence = 2N cycles (erase) or N (draw only), given ready stays high.
// - Handshake:
//   - A write is issued only while ready=1.
//   - If ready falls mid-sequence, FSM holds state/idx with write_en=0 and resumes
//     when ready=1.
// - Overlap:
//   - A tick arriving while FSM != IDLE sets pending; no sprite update happens then.
//   - On return to IDLE with pending, the tick is processed at once.
//   - pending saturates at 1 (extra ticks dropped).
// - Output hold: pixel_addr/pixel_value hold last values when write_en=0.
// - busy = (FSM != IDLE) | pending.
// - Collisions: DRAW after all ERASEs, higher index written last wins the pixel.
// TESTING
//   1. Reset, N=4, step_div=0, run=1, ready pulses:
//      -> frame 1: 4 draws at addr 0x00,0x0F,0x10,0x1F;
//      -> frame 2: erases those 4, then draws 0x01,0x0E,0x11,0x1E.
//   2. Wrap, N=1, step_div=0 -> after 8 steps col sequence 1..7,0; addr 0x07 then 0x00.
//   3. Bounce, N=1 -> cols 1..7,6,5; no col beyond 7; dir flips exactly at col 7 and col 0.
//   4. step_div=3 -> col advances on ticks 1,5,9 only; other ticks draw-only (N writes).
//   5. ready drops for 5 cycles after 2nd write -> write_en low 5 cycles;
//      remaining writes follow with no loss/duplication.
//   6. Assert rst_n mid-ERASE -> write_en=0 same cycle; next frame is draw-only at reset positions.

Source files
------------

// File: rtl/sprite_animator.sv
// sprite_animator
//   Animates N_SPRITES one-pixel sprites on the 8x8 colour shield, sprite i on
//   row i. On each shield frame (rising edge of ready) the frame prescaler may
//   allow a step. Every sprite then moves one column, with wrap or bounce at the
//   edges. The block then issues a write burst to the shield: erase of the old
//   positions (if a move happened) followed by a draw of all current positions.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   run          1 = sprites advance on step frames, 0 = frozen (still redrawn)
//   bounce       0 = wrap at edges, 1 = bounce at edges (sampled at step time)
//   step_div     frames per step minus one (sampled at prescaler reload)
//   ready        shield INPUT phase; writes only go out while high
//   write_en     one-cycle pixel write strobe
//   pixel_addr   {row, col} of the current write
//   pixel_value  RGB of the current write (zero for erase)
//   busy         a write burst is active or a frame is pending
module sprite_animator #(
    parameter int           N_SPRITES = 4,
    parameter int           DIV_W     = 8,
    parameter logic [191:0] PALETTE   = {8{24'hff0000}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             bounce,
    input  logic [DIV_W-1:0] step_div,
    input  logic             ready,
    output logic             write_en,
    output logic [5:0]       pixel_addr,
    output logic [23:0]      pixel_value,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW} state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             ready_q;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             first_q, first_d;
    logic             pend_q, pend_d;
    logic [2:0]       col_q [N_SPRITES];
    logic [2:0]       col_d [N_SPRITES];
    logic [2:0]       old_q [N_SPRITES];
    logic [2:0]       old_d [N_SPRITES];
    logic             dir_q [N_SPRITES];   // 1 = moving right (+1)
    logic             dir_d [N_SPRITES];
    logic [5:0]       addr_hold_q, addr_hold_d;
    logic [23:0]      val_hold_q, val_hold_d;

    logic        tick, proc, step, move;
    logic [2:0]  sel_col, sel_old;
    logic [23:0] sel_pal;
    logic [5:0]  cur_addr;
    logic [23:0] cur_val;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        presc_d     = presc_q;
        first_d     = first_q;
        pend_d      = pend_q;
        addr_hold_d = addr_hold_q;
        val_hold_d  = val_hold_q;
        step        = 1'b0;
        move        = 1'b0;
        sel_col     = '0;
        sel_old     = '0;
        sel_pal     = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            col_d[i] = col_q[i];
            old_d[i] = old_q[i];
            dir_d[i] = dir_q[i];
        end

        tick = ready & ~ready_q;
        // A pending frame is served as soon as the FSM is back in IDLE.
        proc = (state_q == S_IDLE) & (tick | pend_q);

        if (proc) begin
            if (presc_q == '0) begin
                presc_d = step_div;
                step    = run;
            end else begin
                presc_d = presc_q - 1'b1;
            end
            // The very first frame only paints the start positions.
            move    = step & ~first_q;
            first_d = 1'b0;
            pend_d  = 1'b0;
            if (move) begin
                for (int i = 0; i < N_SPRITES; i++) begin
                    old_d[i] = col_q[i];
                    if (bounce && dir_q[i] && col_q[i] == 3'd7) begin
                        dir_d[i] = 1'b0;
                        col_d[i] = 3'd6;
                    end else if (bounce && !dir_q[i] && col_q[i] == 3'd0) begin
                        dir_d[i] = 1'b1;
                        col_d[i] = 3'd1;
                    end else begin
                        col_d[i] = dir_q[i] ? col_q[i] + 3'd1 : col_q[i] - 3'd1;
                    end
                end
            end
            state_d = move ? S_ERASE : S_DRAW;
            idx_d   = 3'd0;
        end else if (tick) begin
            // Tick during a burst: remember it, saturating at one.
            pend_d = 1'b1;
        end

        for (int i = 0; i < N_SPRITES; i++) begin
            if (idx_q == 3'(i)) begin
                sel_col = col_q[i];
                sel_old = old_q[i];
                sel_pal = PALETTE[24*i +: 24];
            end
        end

        cur_addr = {idx_q, (state_q == S_ERASE) ? sel_old : sel_col};
        cur_val  = (state_q == S_ERASE) ? 24'h000000 : sel_pal;
        // Gated directly by ready so no write leaves outside the INPUT phase.
        write_en = (state_q != S_IDLE) & ready;

        if (write_en) begin
            addr_hold_d = cur_addr;
            val_hold_d  = cur_val;
            if (idx_q == 3'(N_SPRITES - 1)) begin
                idx_d   = 3'd0;
                state_d = (state_q == S_ERASE) ? S_DRAW : S_IDLE;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end

        pixel_addr  = write_en ? cur_addr : addr_hold_q;
        pixel_value = write_en ? cur_val  : val_hold_q;
        busy        = (state_q != S_IDLE) | pend_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            ready_q     <= 1'b0;
            presc_q     <= '0;
            first_q     <= 1'b1;
            pend_q      <= 1'b0;
            addr_hold_q <= '0;
            val_hold_q  <= '0;
            for (int i = 0; i < N_SPRITES; i++) begin
                col_q[i] <= (i % 2 == 0) ? 3'd0 : 3'd7;
                old_q[i] <= 3'd0;
                dir_q[i] <= (i % 2 == 0);
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ready_q     <= ready;
            presc_q     <= presc_d;
            first_q     <= first_d;
            pend_q      <= pend_d;
            addr_hold_q <= addr_hold_d;
            val_hold_q  <= val_hold_d;
            for (int i = 0; i < N_SPRITES; i++) begin
                col_q[i] <= col_d[i];
                old_q[i] <= old_d[i];
                dir_q[i] <= dir_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sprite_animator.sv
// Directed bench for sprite_animator: a 4-sprite instance with a distinct
// palette and a 1-sprite instance with the default palette share all inputs.
module tb_sprite_animator;

    localparam logic [191:0] PAL = {24'h880000, 24'h770000, 24'h660000, 24'h550000,
                                    24'h440000, 24'h330000, 24'h220000, 24'h110000};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b1;
    logic        bounce = 1'b0;
    logic [7:0]  step_div = 8'd0;
    logic        ready = 1'b0;
    logic        we4, we1, busy4, busy1;
    logic [5:0]  a4, a1;
    logic [23:0] v4, v1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tcyc = 0;

    logic [29:0] q4[$];
    logic [29:0] q1[$];
    int          c4[$];

    logic [29:0] exp_f1 [4] = '{{6'h00, 24'h110000}, {6'h0F, 24'h220000},
                                {6'h10, 24'h330000}, {6'h1F, 24'h440000}};
    logic [29:0] exp_f2 [8] = '{{6'h00, 24'h0}, {6'h0F, 24'h0}, {6'h10, 24'h0}, {6'h1F, 24'h0},
                                {6'h01, 24'h110000}, {6'h0E, 24'h220000},
                                {6'h11, 24'h330000}, {6'h1E, 24'h440000}};
    int bcol0 [9] = '{1, 2, 3, 4, 5, 6, 7, 6, 5};
    int bcol1 [9] = '{6, 5, 4, 3, 2, 1, 0, 1, 2};
    int dsize [9] = '{2, 1, 1, 1, 2, 1, 1, 1, 2};
    int dcol  [9] = '{1, 1, 1, 1, 2, 2, 2, 2, 3};

    sprite_animator #(.N_SPRITES(4), .DIV_W(8), .PALETTE(PAL)) u4 (
        .clk(clk), .rst_n(rst_n), .run(run), .bounce(bounce), .step_div(step_div),
        .ready(ready), .write_en(we4), .pixel_addr(a4), .pixel_value(v4), .busy(busy4));

    sprite_animator #(.N_SPRITES(1), .DIV_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .run(run), .bounce(bounce), .step_div(step_div),
        .ready(ready), .write_en(we1), .pixel_addr(a1), .pixel_value(v1), .busy(busy1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (we4) begin
                q4.push_back({a4, v4});
                c4.push_back(cyc);
            end
            if (we1) q1.push_back({a1, v1});
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ready = 1'b0;
        tick_clk(3);
        rst_n = 1'b1;
        tick_clk(2);
    endtask

    // Low phase then a rising ready edge (tick in cycle tcyc), held high for hi cycles.
    task automatic frame(input int hi);
        ready = 1'b0;
        tick_clk(2);
        q4.delete();
        q1.delete();
        c4.delete();
        ready = 1'b1;
        tcyc = cyc;
        tick_clk(hi);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick_clk(2);
        @(negedge clk);
        chk("rst_we", we4, 1'b0);
        chk("rst_addr", a4, 6'h00);
        chk("rst_val", v4, 24'h0);
        chk("rst_busy", busy4, 1'b0);
        tick_clk(1);
        rst_n = 1'b1;
        tick_clk(2);

        // Frame 1: draw-only at start positions, first write one cycle after tick
        ready = 1'b0;
        tick_clk(2);
        q4.delete(); q1.delete(); c4.delete();
        ready = 1'b1;
        tcyc = cyc;
        @(negedge clk);
        chk("f1_tick_we", we4, 1'b0);
        tick_clk(10);
        chk("f1_n", q4.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("f1_w%0d", k), q4[k], exp_f1[k]);
            chk($sformatf("f1_c%0d", k), c4[k] - tcyc, k + 1);
        end
        @(negedge clk);
        chk("hold_we", we4, 1'b0);
        chk("hold_addr", a4, 6'h1F);
        chk("hold_val", v4, 24'h440000);
        chk("hold_busy", busy4, 1'b0);
        tick_clk(1);

        // Frame 2: erase then draw one column on
        frame(12);
        chk("f2_n", q4.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("f2_w%0d", k), q4[k], exp_f2[k]);
            chk($sformatf("f2_c%0d", k), c4[k] - tcyc, k + 1);
        end

        // Wrap on the single sprite: cols 2..7 then 0
        for (int k = 0; k < 7; k++) begin
            frame(12);
            chk($sformatf("wrap_n%0d", k), q1.size(), 2);
            chk($sformatf("wrap_e%0d", k), q1[0], {3'd0, 3'(k + 1), 24'h0});
            chk($sformatf("wrap_d%0d", k), q1[1], {3'd0, 3'((k + 2) % 8), 24'hff0000});
        end

        // Frozen: redraw only
        run = 1'b0;
        frame(12);
        chk("frz_n", q1.size(), 1);
        chk("frz_d", q1[0], {6'h00, 24'hff0000});
        run = 1'b1;

        // Bounce
        bounce = 1'b1;
        do_reset();
        frame(12);
        chk("bnc_first_n", q1.size(), 1);
        for (int k = 0; k < 9; k++) begin
            frame(12);
            chk($sformatf("bnc0_d%0d", k), q1[1], {3'd0, 3'(bcol0[k]), 24'hff0000});
            chk($sformatf("bnc1_d%0d", k), q4[5], {3'd1, 3'(bcol1[k]), 24'h220000});
        end
        bounce = 1'b0;

        // Prescaler: with step_div=3 steps on ticks 1,5,9
        do_reset();
        frame(8);
        step_div = 8'd3;
        for (int k = 0; k < 9; k++) begin
            frame(12);
            chk($sformatf("div_n%0d", k), q1.size(), dsize[k]);
            chk($sformatf("div_d%0d", k), q1[q1.size() - 1], {3'd0, 3'(dcol[k]), 24'hff0000});
        end
        step_div = 8'd0;

        // ready drops for 5 cycles after the 2nd write
        do_reset();
        frame(8);
        ready = 1'b0;
        tick_clk(2);
        q4.delete(); q1.delete(); c4.delete();
        ready = 1'b1;
        tcyc = cyc;
        tick_clk(3);
        ready = 1'b0;
        @(negedge clk);
        chk("drop_we", we4, 1'b0);
        chk("drop_busy", busy4, 1'b1);
        tick_clk(5);
        ready = 1'b1;
        tick_clk(24);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drop_w%0d", k), q4[k], exp_f2[k]);
            chk($sformatf("drop_c%0d", k), c4[k] - tcyc, (k < 2) ? k + 1 : k + 6);
        end
        chk("pend_w", q4[8], {6'h01, 24'h0});
        chk("pend_c", c4[8] - tcyc, 15);

        // Reset in the middle of an erase burst
        do_reset();
        frame(8);
        ready = 1'b0;
        tick_clk(2);
        q4.delete(); q1.delete(); c4.delete();
        ready = 1'b1;
        tick_clk(2);
        rst_n = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        chk("mid_rst_we", we4, 1'b0);
        chk("mid_rst_busy", busy4, 1'b0);
        chk("mid_rst_n", q4.size(), 1);
        tick_clk(2);
        rst_n = 1'b1;
        tick_clk(2);
        frame(10);
        chk("post_rst_n", q4.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("post_rst_w%0d", k), q4[k], exp_f1[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
